// File: rtl/pipe_in_rx_buffer.sv
// Receive-side FWFT buffer behind a pipe-in endpoint. It counts accepted words, flags dropped
// words, and provides an advisory block-level ready back toward the host.
module pipe_in_rx_buffer #(
   parameter int unsigned DEPTH_LOG2  = 4,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic                  ti_clk,
   input  logic                  rst_n,
   input  logic                  ep_write,
   input  logic [31:0]           ep_dataout,
   output logic                  ep_ready,
   output logic [31:0]           out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic [31:0]           word_count,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam int unsigned LvlW  = DEPTH_LOG2 + 1;
   localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);
   localparam logic [LvlW-1:0] BlockLvl = LvlW'(BLOCK_WORDS);

   logic [31:0]           mem [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]       level_q, level_d;
   logic [31:0]           word_count_q, word_count_d;
   logic                  overflow_q, overflow_d;

   logic full;
   logic pop;
   logic push;
   logic drop;
   logic [LvlW-1:0] free_slots;

   assign full = (level_q == DepthLvl);
   assign pop  = (level_q != '0) && out_ready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push = ep_write && (!full || pop);
   assign drop = ep_write && full && !pop;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;

      if (push) begin
         wr_ptr_d     = wr_ptr_q + 1'b1;
         word_count_d = word_count_q + 32'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      if (ovf_clr) begin
         overflow_d = 1'b0;
      end else if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge ti_clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage is not reset; writes are suppressed while reset is held.
   always_ff @(posedge ti_clk) begin
      if (rst_n && push) begin
         mem[wr_ptr_q] <= ep_dataout;
      end
   end

   assign free_slots = DepthLvl - level_q;
   assign ep_ready   = (free_slots >= BlockLvl);
   assign out_valid  = (level_q != '0);
   assign out_data   = mem[rd_ptr_q];
   assign level      = level_q;
   assign word_count = word_count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_pipe_in_rx_buffer.sv
// Directed bench for pipe_in_rx_buffer: vector table for fill/overflow/full-swap/drain,
// then hand-written sequences for streaming across pointer wrap and mid-stream reset.
module tb_pipe_in_rx_buffer;

   logic        ti_clk = 1'b0;
   logic        rst_n;
   logic        ep_write;
   logic [31:0] ep_dataout;
   logic        ep_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  level;
   logic [31:0] word_count;
   logic        overflow;
   logic        ovf_clr;

   int errors = 0;
   int checks = 0;

   always #5 ti_clk = ~ti_clk;

   pipe_in_rx_buffer #(
      .DEPTH_LOG2  (4),
      .BLOCK_WORDS (4)
   ) dut (
      .ti_clk     (ti_clk),
      .rst_n      (rst_n),
      .ep_write   (ep_write),
      .ep_dataout (ep_dataout),
      .ep_ready   (ep_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level),
      .word_count (word_count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   typedef struct {
      logic        rst_n;
      logic        wr;
      logic [31:0] din;
      logic        rdy;
      logic        clr;
      int          lvl;
      logic        vld;
      logic        epr;
      logic        ovf;
      logic        chk_dout;
      logic [31:0] dout;
      logic [31:0] wc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic r, logic w, logic [31:0] d, logic rd, logic c, int lv,
                               logic vl, logic er, logic ov, logic cd, logic [31:0] dq,
                               logic [31:0] wcnt);
      vec_t v;
      v.rst_n = r; v.wr = w; v.din = d; v.rdy = rd; v.clr = c; v.lvl = lv; v.vld = vl;
      v.epr = er; v.ovf = ov; v.chk_dout = cd; v.dout = dq; v.wc = wcnt;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [31:0] d, input logic rd,
                        input logic c);
      rst_n = r; ep_write = w; ep_dataout = d; out_ready = rd; ovf_clr = c;
   endtask

   task automatic tick();
      @(posedge ti_clk);
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      #2;

      // Reset (with a write that must be ignored), then idle.
      add(0, 1, 32'hAAAA, 1, 1, 0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 32'h0,    0, 0, 0, 0, 1, 0, 0, 0, 0);
      // Fill 16 words; ep_ready drops once level reaches 13.
      for (int i = 0; i < 16; i++)
         add(1, 1, 32'h1000 + i, 0, 0, i + 1, 1, (16 - (i + 1)) >= 4, 0, 1, 32'h1000, i + 1);
      // Overflow while full, hold, then clear.
      add(1, 1, 32'hDEAD, 0, 0, 16, 1, 0, 1, 1, 32'h1000, 16);
      add(1, 0, 32'h0,    0, 0, 16, 1, 0, 1, 1, 32'h1000, 16);
      add(1, 0, 32'h0,    0, 1, 16, 1, 0, 0, 1, 32'h1000, 16);
      // Full with simultaneous push and pop.
      add(1, 1, 32'hBEEF, 1, 0, 16, 1, 0, 0, 1, 32'h1001, 17);
      // Drain: heads 0x1002..0x100F then 0xBEEF as the 16th word read.
      for (int j = 0; j < 15; j++)
         add(1, 0, 32'h0, 1, 0, 15 - j, 1, (j + 1) >= 4, 0, 1,
             (j < 14) ? 32'h1002 + j : 32'hBEEF, 17);
      add(1, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0, 17);

      foreach (vecs[k]) begin
         drive(vecs[k].rst_n, vecs[k].wr, vecs[k].din, vecs[k].rdy, vecs[k].clr);
         tick();
         chk($sformatf("v%0d level", k), 32'(level), vecs[k].lvl);
         chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].vld));
         chk($sformatf("v%0d ep_ready", k), 32'(ep_ready), 32'(vecs[k].epr));
         chk($sformatf("v%0d overflow", k), 32'(overflow), 32'(vecs[k].ovf));
         chk($sformatf("v%0d word_count", k), word_count, vecs[k].wc);
         if (vecs[k].chk_dout)
            chk($sformatf("v%0d out_data", k), out_data, vecs[k].dout);
      end

      // Streaming 40 words across pointer wrap with out_ready held high.
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 1'b1, 32'(i), 1'b1, 1'b0);
         if (i > 0) begin
            chk($sformatf("stream%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d data", i), out_data, 32'(i - 1));
         end
         tick();
         chk($sformatf("stream%0d level", i), 32'(level), 32'd1);
      end
      chk("stream last data", out_data, 32'd39);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("stream end level", 32'(level), 32'd0);
      chk("stream end valid", 32'(out_valid), 32'd0);
      chk("stream word_count", word_count, 32'd40);

      // Mid-stream reset at level 7.
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b1, 32'h70 + i, 1'b0, 1'b0);
         tick();
      end
      chk("pre-reset level", 32'(level), 32'd7);
      drive(1'b0, 1'b1, 32'h99, 1'b1, 1'b0);
      tick();
      chk("midrst level", 32'(level), 32'd0);
      chk("midrst valid", 32'(out_valid), 32'd0);
      chk("midrst word_count", word_count, 32'd0);
      drive(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("post-reset data", out_data, 32'h55);
      chk("post-reset valid", 32'(out_valid), 32'd1);
      chk("post-reset level", 32'(level), 32'd1);
      chk("post-reset word_count", word_count, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
